// File: rtl/mc_mem_pkg.sv
// Shared types and helpers for the multicycle load/store unit.
// Access sizes, FSM states and the alignment check live here.
package mc_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_CAPT = 3'd2,
        WR      = 3'd3,
        FAULT   = 3'd4
    } state_t;

    // Reserved size is treated as a fault alongside real misalignment.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic bad;
        case (size)
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mc_mem_access_unit_lane_align.sv
// Byte-lane steering: load extraction/extension and store merge.
// Purely combinational; the owning FSM decides when results are used.
module mc_lane_align
    import mc_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        sign_ext_i,
    input  logic [31:0] mem_rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v    = mem_rdata_i[{lane_i, 3'b000} +: 8];
        half_v    = mem_rdata_i[{lane_i[1], 4'b0000} +: 16];
        ld_data_o = mem_rdata_i;
        st_data_o = mem_rdata_i;
        case (size_i)
            SZ_BYTE: begin
                ld_data_o = {{24{sign_ext_i & byte_v[7]}}, byte_v};
                st_data_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                ld_data_o = {{16{sign_ext_i & half_v[15]}}, half_v};
                st_data_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                ld_data_o = mem_rdata_i;
                st_data_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mc_mem_access_unit.sv
// Load/store unit between the multicycle datapath and single-port memory.
// Sub-word stores use read-modify-write; done/err are registered pulses.
module mc_mem_access_unit
    import mc_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] LAT = 3'(MEM_RD_LAT);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [1:0]          size_q;
    logic                sext_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                mem_wr_q, mem_wr_d;
    logic                accept;
    logic [DATA_W-1:0]   ld_data;
    logic [DATA_W-1:0]   st_data;

    assign accept = (state_q == IDLE) && req;

    mc_lane_align u_align (
        .size_i      (size_q),
        .lane_i      (addr_q[1:0]),
        .sign_ext_i  (sext_q),
        .mem_rdata_i (mem_rdata),
        .wdata_i     (wdata_q),
        .ld_data_o   (ld_data),
        .st_data_o   (st_data)
    );

    // The address reaches memory in the accept cycle so the read
    // latency is counted from acceptance, then holds from addr_q.
    assign mem_addr = (accept && !Reset)
                    ? {addr[ADDR_W-1:2], 2'b00}
                    : {addr_q[ADDR_W-1:2], 2'b00};

    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_wr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (is_misaligned(size, addr[1:0])) begin
                        state_d = FAULT;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (we && size == SZ_WORD) begin
                        state_d     = WR;
                        mem_wr_d    = 1'b1;
                        done_d      = 1'b1;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = 3'd1;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == LAT) begin
                    cnt_d   = '0;
                    state_d = RD_CAPT;
                    if (we_q) begin
                        mem_wdata_d = st_data;
                    end else begin
                        rdata_d = ld_data;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RD_CAPT: begin
                if (we_q) begin
                    state_d  = WR;
                    mem_wr_d = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WR:      state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            sext_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_wr_q    <= mem_wr_d;
            if (accept) begin
                we_q    <= we;
                size_q  <= size;
                sext_q  <= sign_ext;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mc_mem_access_unit.sv
// Self-checking bench for mc_mem_access_unit with a byte-level
// reference memory model and a latency-pipelined memory.
module tb_mc_mem_access_unit;

    localparam int LAT = 3;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errs = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    mc_mem_access_unit #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .MEM_RD_LAT (LAT)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Bench memory: 64 words aliased on addr[7:2], read data LAT cycles
    // after the address is presented.
    logic [31:0] mem [64] = '{default: 32'h0};
    logic [31:0] pipe [LAT];
    int wr_cnt = 0;
    int done_cnt = 0;

    always @(posedge Clk) begin
        if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
        pipe[0] <= mem[mem_addr[7:2]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        if (mem_wr) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    assign mem_rdata = pipe[LAT-1];

    // Reference model: little-endian byte array plus expected rdata.
    logic [7:0]  refb [256] = '{default: 8'h0};
    logic [31:0] exp_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {refb[8'(b+3)], refb[8'(b+2)], refb[8'(b+1)], refb[b]};
    endfunction

    task automatic op(input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit hold);
        bit flt;
        bit st;
        int nb;
        int lat;
        int n;
        int w0;
        int d0;
        logic [31:0] v;
        flt = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
              (sz == 2'd2 && a[1:0] != 2'b00);
        st  = w && !flt;
        nb  = 1 << sz;
        if (flt) lat = 1;
        else if (w && sz == 2'd2) lat = 1;
        else if (w) lat = LAT + 2;
        else lat = LAT + 1;
        if (!flt) begin
            if (!w) begin
                v = 32'h0;
                for (int i = 0; i < nb; i++)
                    v |= 32'(refb[8'(a[7:0] + i)]) << (8 * i);
                if (sx && v[8*nb-1]) v |= (~32'h0) << (8 * nb);
                exp_rdata = v;
            end else begin
                for (int i = 0; i < nb; i++)
                    refb[8'(a[7:0] + i)] = wd[8*i +: 8];
            end
        end
        w0 = wr_cnt;
        d0 = done_cnt;
        @(negedge Clk);
        we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
            if (!hold) req = 1'b0;
            we = ~w; size = 2'($urandom); sign_ext = ~sx;
            addr = $urandom; wdata = $urandom;
        end while (!done && n < 20);
        req = 1'b0;
        chk("latency", 32'(n), 32'(lat));
        chk("err", 32'(err), 32'(flt));
        chk("busy_at_done", 32'(busy), 32'h1);
        chk("mem_wr_at_done", 32'(mem_wr), 32'(st));
        if (st) chk("mem_wdata", mem_wdata, model_word(a));
        if (!flt) chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("rdata", rdata, exp_rdata);
        @(negedge Clk);
        chk("idle_flags", 32'({busy, done, err, mem_wr}), 32'h0);
        chk("write_count", 32'(wr_cnt - w0), 32'(st));
        chk("done_count", 32'(done_cnt - d0), 32'h1);
        if (!flt) chk("mem_word", mem[a[7:2]], model_word(a));
    endtask

    initial begin
        int w0;
        int d0;
        repeat (3) @(negedge Clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_flags", 32'({busy, done, err, mem_wr}), 32'h0);
        Reset = 1'b0;

        op(1, 2'd2, 0, 32'h10, 32'h8765_4321, 0);
        op(1, 2'd2, 0, 32'h20, 32'h1122_3344, 0);
        op(1, 2'd2, 0, 32'h30, 32'hCAFE_F00D, 0);

        op(0, 2'd2, 0, 32'h10, 32'h0, 0);
        chk("tp_word", rdata, 32'h8765_4321);
        op(0, 2'd0, 1, 32'h13, 32'h0, 0);
        chk("tp_byte_s", rdata, 32'hFFFF_FF87);
        op(0, 2'd0, 0, 32'h13, 32'h0, 0);
        chk("tp_byte_z", rdata, 32'h0000_0087);
        op(0, 2'd1, 1, 32'h12, 32'h0, 0);
        chk("tp_half_s", rdata, 32'hFFFF_8765);

        op(1, 2'd0, 0, 32'h21, 32'h1234_56AB, 0);
        chk("tp_sb", mem[8], 32'h1122_AB44);
        op(1, 2'd1, 0, 32'h22, 32'h7777_BEEF, 0);
        chk("tp_sh", mem[8], 32'hBEEF_AB44);

        op(0, 2'd1, 1, 32'h05, 32'h0, 0);
        op(1, 2'd3, 0, 32'h00, 32'hFFFF_FFFF, 0);
        chk("tp_fault_rdata", rdata, 32'hFFFF_8765);

        op(0, 2'd0, 1, 32'h13, 32'h0, 1);
        op(1, 2'd1, 0, 32'h2E, 32'h0000_1357, 1);

        op(1, 2'd2, 0, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 0);
        op(0, 2'd2, 0, 32'hFFFF_FFFC, 32'h0, 0);
        chk("tp_wrap", rdata, 32'hA5A5_5A5A);

        // Abort a byte store while it waits on memory.
        w0 = wr_cnt;
        d0 = done_cnt;
        @(negedge Clk);
        we = 1; size = 2'd0; sign_ext = 0; addr = 32'h24;
        wdata = 32'hCD; req = 1'b1;
        @(negedge Clk);
        req = 1'b0;
        @(negedge Clk);
        chk("abort_busy", 32'(busy), 32'h1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_mem_wdata", mem_wdata, 32'h0);
        chk("abort_flags", 32'({busy, done, err, mem_wr}), 32'h0);
        Reset = 1'b0;
        exp_rdata = 32'h0;
        repeat (LAT + 3) @(negedge Clk);
        chk("abort_writes", 32'(wr_cnt - w0), 32'h0);
        chk("abort_dones", 32'(done_cnt - d0), 32'h0);
        chk("abort_mem", mem[9], model_word(32'h24));
        op(0, 2'd2, 0, 32'h20, 32'h0, 0);
        chk("post_abort_load", rdata, 32'hBEEF_AB44);

        for (int k = 0; k < 60; k++) begin
            op(1'($urandom), 2'($urandom), 1'($urandom), $urandom,
               $urandom, bit'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
